// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl: lookup/miss/refill/flush sequencer for an N-way instruction-cache tag array
module icache_tag_ctrl #(
    parameter int N_WAYS     = 4,
    parameter int TAG_WIDTH  = 20,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        lookup_valid_i,
    output logic                        lookup_ready_o,
    input  logic [TAG_WIDTH-1:0]        lookup_tag_i,
    input  logic [ADDR_WIDTH-1:0]       lookup_index_i,
    output logic                        hit_o,
    output logic                        miss_o,
    output logic [N_WAYS-1:0]           hit_way_o,
    output logic [N_WAYS-1:0]           tag_req_o,
    output logic [N_WAYS-1:0]           tag_we_o,
    output logic                        tag_vbit_o,
    output logic                        tag_flush_o,
    output logic [TAG_WIDTH-1:0]        tag_data_o,
    output logic [ADDR_WIDTH-1:0]       tag_addr_o,
    input  logic [N_WAYS*TAG_WIDTH-1:0] tag_data_i,
    input  logic [N_WAYS-1:0]           tag_vbit_i,
    output logic                        l2_req_o,
    input  logic                        l2_ack_i,
    output logic [TAG_WIDTH-1:0]        l2_tag_o,
    output logic [ADDR_WIDTH-1:0]       l2_index_o,
    input  logic                        l2_fill_valid_i,
    output logic                        refill_done_o,
    input  logic                        flush_i,
    output logic                        flush_done_o,
    output logic                        busy_o
);
    localparam int PW = $clog2(N_WAYS);
    typedef enum logic [2:0] {IDLE, COMPARE, MISS_REQ, MISS_WAIT, REFILL, FLUSH} state_t;
    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d, vic_q, vic_d, inv_idx;
    logic                  vic_rr_q, vic_rr_d, pend_q, pend_d, inv_any;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [N_WAYS-1:0]     hit_first;
    assign tag_data_o = tag_q;
    assign l2_tag_o   = tag_q;
    assign l2_index_o = idx_q;
    assign busy_o     = (state_q != IDLE) || pend_q;
    // lowest-index hitting way and lowest-index invalid way (descending scan so the lowest wins)
    always_comb begin
        hit_first = '0;
        inv_idx   = '0;
        inv_any   = 1'b0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (tag_vbit_i[w] && tag_data_i[w*TAG_WIDTH +: TAG_WIDTH] == tag_q) hit_first = N_WAYS'(1) << w;
            if (!tag_vbit_i[w]) begin
                inv_any = 1'b1;
                inv_idx = PW'(w);
            end
        end
    end
    // next-state and output decode
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        vic_d          = vic_q;
        vic_rr_d       = vic_rr_q;
        tag_d          = tag_q;
        idx_d          = idx_q;
        pend_d         = pend_q | (flush_i & (state_q != IDLE));
        lookup_ready_o = 1'b0;
        hit_o          = 1'b0;
        miss_o         = 1'b0;
        hit_way_o      = '0;
        tag_req_o      = '0;
        tag_we_o       = '0;
        tag_vbit_o     = 1'b0;
        tag_flush_o    = 1'b0;
        tag_addr_o     = idx_q;
        l2_req_o       = 1'b0;
        refill_done_o  = 1'b0;
        flush_done_o   = 1'b0;
        case (state_q)
            IDLE: begin
                lookup_ready_o = !pend_q && !flush_i;
                if (pend_q || flush_i) state_d = FLUSH;
                else if (lookup_valid_i) begin
                    tag_d      = lookup_tag_i;
                    idx_d      = lookup_index_i;
                    tag_req_o  = '1;
                    tag_addr_o = lookup_index_i;
                    state_d    = COMPARE;
                end
            end
            COMPARE: begin
                if (|hit_first) begin
                    hit_o     = 1'b1;
                    hit_way_o = hit_first;
                    state_d   = IDLE;
                end else begin
                    miss_o   = 1'b1;
                    vic_d    = inv_any ? inv_idx : ptr_q;
                    vic_rr_d = !inv_any;
                    state_d  = MISS_REQ;
                end
            end
            MISS_REQ: begin
                l2_req_o = 1'b1;
                if (l2_ack_i) state_d = l2_fill_valid_i ? REFILL : MISS_WAIT;
            end
            MISS_WAIT: state_d = l2_fill_valid_i ? REFILL : MISS_WAIT;
            REFILL: begin
                refill_done_o = 1'b1;
                tag_vbit_o    = 1'b1;
                state_d       = IDLE;
                if (!pend_q) begin
                    tag_req_o = N_WAYS'(1) << vic_q;
                    tag_we_o  = N_WAYS'(1) << vic_q;
                    ptr_d     = vic_rr_q ? ptr_q + PW'(1) : ptr_q;
                end
            end
            FLUSH: begin
                tag_flush_o  = 1'b1;
                flush_done_o = 1'b1;
                pend_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            vic_q    <= '0;
            vic_rr_q <= 1'b0;
            pend_q   <= 1'b0;
            tag_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            vic_q    <= vic_d;
            vic_rr_q <= vic_rr_d;
            pend_q   <= pend_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
        end
    end
endmodule

// File: doc/icache_tag_ctrl.md
Name: icache_tag_ctrl

Overview:
Sequencer for the instruction-cache tag array: drives N_WAYS tag way memories sharing one index/tag write bus. Accepts lookup requests, reads all ways in parallel, compares tags and valid bits, and reports a hit or a miss. On a miss it issues an L2 request and waits for the fill. On the fill it writes the new tag with a valid bit into a selected victim way. It also sequences whole-cache flushes.

Parameters:
N_WAYS, 4, number of tag ways (power of 2, ≥2)
TAG_WIDTH, 20, tag width in bits
ADDR_WIDTH, 8, set-index width (depth 2**ADDR_WIDTH)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; synchronous, active-low
lookup_valid_i  in  1  lookup request
lookup_ready_o  out  1  controller can accept a lookup
lookup_tag_i  in  TAG_WIDTH  tag to compare
lookup_index_i  in  ADDR_WIDTH  set index
hit_o  out  1  one-cycle pulse: lookup hit
miss_o  out  1  one-cycle pulse: lookup missed
hit_way_o  out  N_WAYS  one-hot hit way, valid with hit_o
tag_req_o  out  N_WAYS  per-way memory request
tag_we_o  out  N_WAYS  per-way write enable
tag_vbit_o  out  1  valid bit to write
tag_flush_o  out  1  clears all valid bits (broadcast)
tag_data_o  out  TAG_WIDTH  tag write data (broadcast)
tag_addr_o  out  ADDR_WIDTH  index (broadcast)
tag_data_i  in  N_WAYS*TAG_WIDTH  per-way read tags; way w at [w*TAG_WIDTH +: TAG_WIDTH]
tag_vbit_i  in  N_WAYS  per-way read valid bits
l2_req_o  out  1  miss request, held until acked
l2_ack_i  in  1  L2 accepted request
l2_tag_o  out  TAG_WIDTH  missing tag
l2_index_o  out  ADDR_WIDTH  missing index
l2_fill_valid_i  in  1  fill data returned (one-cycle pulse)
refill_done_o  out  1  one-cycle pulse: tag written
flush_i  in  1  flush request (pulse)
flush_done_o  out  1  one-cycle pulse: flush issued
busy_o  out  1  state != IDLE or flush pending

Behaviour:
- States: IDLE, COMPARE, MISS_REQ, MISS_WAIT, REFILL, FLUSH.
- Reset (rstn_i low at a clock edge): state is IDLE. All outputs are 0 except lookup_ready_o=1. Round-robin pointer is 0. Flush-pending flag is cleared. Registered tag and index are 0. Reset mid-operation abandons any L2 transaction; the L2 side must be reset together with this block.
- IDLE: lookup_ready_o=1 only when no flush is pending and flush_i=0. Flush (pending or new) has priority: go to FLUSH.
- IDLE lookup: when lookup_valid_i & lookup_ready_o:
  - register tag and index;
  - drive tag_req_o=all-ones, tag_we_o=0, tag_addr_o=lookup_index_i in the same cycle;
  - go to COMPARE.
- COMPARE (one cycle after accept):
  - way w hits if tag_vbit_i[w] and tag_data_i way w equals the registered tag;
  - if several ways hit, the lowest index wins;
  - on hit: hit_o=1 and hit_way_o one-hot, then go to IDLE. Load-to-hit latency is 1 cycle;
  - on miss: miss_o=1, then go to MISS_REQ;
  - victim is the lowest-index invalid way if any, else the round-robin pointer. The victim is latched in this cycle.
- MISS_REQ: l2_req_o=1 with l2_tag_o and l2_index_o from the registered values, held stable until l2_ack_i. Go to MISS_WAIT on the cycle l2_ack_i=1. If l2_fill_valid_i arrives in the same cycle as l2_ack_i, go straight to REFILL.
- MISS_WAIT: wait for l2_fill_valid_i, then go to REFILL.
- REFILL (one cycle):
  - tag_req_o and tag_we_o are one-hot at the victim; tag_vbit_o=1; tag_data_o is the registered tag; tag_addr_o is the registered index;
  - refill_done_o=1;
  - the round-robin pointer increments modulo N_WAYS, but only if the victim came from the pointer;
  - go to IDLE;
  - if a flush is pending, the write is suppressed (tag_req_o=0, tag_we_o=0), refill_done_o is still pulsed, and the pointer does not move.
- FLUSH (one cycle): tag_flush_o=1, flush_done_o=1, pending cleared, go to IDLE. No lookup is accepted in this cycle.
- flush_i in any non-IDLE state sets the pending flag. Repeated flush_i pulses while pending coalesce into a single flush.
- Outside the cycles named above: tag_req_o, tag_we_o, tag_flush_o, hit_o, miss_o, refill_done_o and flush_done_o are 0.

Test Plan:
- Reset, flush, then lookup idx 0x10 tag 0xABCDE → miss_o; l2_req_o held until ack; fill → REFILL writes way 0 (first invalid), vbit=1, refill_done_o; relookup → hit_o, hit_way_o=4'b0001, 1 cycle after accept.
- Fill all 4 ways of idx 0x22 with distinct tags, then miss on a 5th tag → victims 0 and 1 in consecutive round-robin refills; the pointer only advances on round-robin victims.
- l2_ack_i delayed 5 cycles → l2_req_o, l2_tag_o and l2_index_o are stable throughout; lookup_ready_o=0 and busy_o=1.
- flush_i during MISS_WAIT → REFILL write suppressed (tag_we_o=0), then FLUSH: tag_flush_o pulses; the next lookup of the same tag misses.
- flush_i and lookup_valid_i together in IDLE → flush taken, lookup_ready_o=0; lookup accepted the cycle after FLUSH.
- rstn_i low during MISS_REQ → next cycle state is IDLE, l2_req_o=0, lookup_ready_o=1, pointer reset to 0.
